// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with a built-in busy-bit scoreboard.
//
// Purpose:
//   NUM_RD combinational read ports and NUM_WR write ports that commit on the clock edge.
//   Each register has a busy bit for RAW stall detection: issue sets it, writeback
//   clears it, and Flush clears all of them. Register 0 is hard-wired zero and is never
//   busy. Out-of-range addresses read as zero and not busy, and writes or issues to them
//   are ignored.
//
// Optional feature:
//   Define REGFILE_WR_BYPASS_EN to forward same-cycle write data, and the cleared busy
//   bit, to reads of the same address.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   WrEn       per-port write enable                    [NUM_WR]
//   WrAddr     write addresses, port k at [k*ADDR_W +: ADDR_W]
//   WrData     write data, port k at [k*XLEN +: XLEN]
//   RdEn       per-port read enable                     [NUM_RD]
//   RdAddr     read addresses, packed as for WrAddr
//   RdData     read data (combinational)
//   RdBusy     busy bit of the addressed register (combinational)
//   IssueEn    mark IssueAddr busy at the next edge
//   IssueAddr  destination register of the issuing instruction
//   Flush      clear all busy bits at the next edge
//   BusyCnt    registered population count of the busy bits
module regfile_mp_sb #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_WR-1:0]        WrEn,
    input  logic [NUM_WR*ADDR_W-1:0] WrAddr,
    input  logic [NUM_WR*XLEN-1:0]   WrData,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*XLEN-1:0]   RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     IssueEn,
    input  logic [ADDR_W-1:0]        IssueAddr,
    input  logic                     Flush,
    output logic [ADDR_W:0]          BusyCnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    // Register 0 has no storage, so both arrays start at index 1.
    logic [NUM_REGS-1:1][XLEN-1:0] regs_q;
    logic [NUM_REGS-1:1]           busy_q;
    logic [NUM_REGS-1:1]           busy_d;
    logic [NUM_REGS-1:1]           wr_hit;
    logic [NUM_REGS-1:1][XLEN-1:0] wr_val;
    logic [NUM_REGS-1:1]           issue_hit;
    logic [CNT_W-1:0]              cnt_d;
    logic [CNT_W-1:0]              busy_cnt_q;

    // Decode writes per register. Scanning ports in ascending order lets the
    // highest-index port win an address collision.
    always_comb begin
        wr_hit    = '0;
        wr_val    = '0;
        issue_hit = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (WrEn[k] && (WrAddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = WrData[k*XLEN +: XLEN];
                end
            end
            issue_hit[r] = IssueEn && (IssueAddr == ADDR_W'(r));
        end
    end

    // Busy priority: issue beats flush, and flush beats write-clear.
    // The busy count is taken from the next-state vector, so it is registered
    // on the same edge as the busy bits themselves.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (issue_hit[r]) begin
                busy_d[r] = 1'b1;
            end else if (Flush) begin
                busy_d[r] = 1'b0;
            end else if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    // Storage, busy bits and the busy count.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q     <= busy_d;
            busy_cnt_q <= cnt_d;
        end
    end

    assign BusyCnt = busy_cnt_q;

    // Read mux. Addresses 0 and >= NUM_REGS match no entry, so they read 0 and not busy.
    always_comb begin
        RdData = '0;
        RdBusy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (RdEn[p]) begin
                for (int unsigned r = 1; r < NUM_REGS; r++) begin
                    if (RdAddr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                        RdData[p*XLEN +: XLEN] = regs_q[r];
                        RdBusy[p]              = busy_q[r];
`ifdef REGFILE_WR_BYPASS_EN
                        // Forward in-flight writeback. A same-cycle issue keeps the register busy.
                        if (wr_hit[r]) begin
                            RdData[p*XLEN +: XLEN] = wr_val[r];
                            RdBusy[p]              = issue_hit[r];
                        end
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed table vectors, a mid-stream reset sequence and random
// stimulus, checked against an array-based reference model of the register file.
module tb_regfile_mp_sb;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 4;
    localparam int NUM_WR   = 2;

    logic                     Clk = 1'b0;
    logic                     Rst = 1'b0;
    logic [NUM_WR-1:0]        WrEn = '0;
    logic [NUM_WR*ADDR_W-1:0] WrAddr = '0;
    logic [NUM_WR*XLEN-1:0]   WrData = '0;
    logic [NUM_RD-1:0]        RdEn = '0;
    logic [NUM_RD*ADDR_W-1:0] RdAddr = '0;
    logic [NUM_RD*XLEN-1:0]   RdData;
    logic [NUM_RD-1:0]        RdBusy;
    logic                     IssueEn = 1'b0;
    logic [ADDR_W-1:0]        IssueAddr = '0;
    logic                     Flush = 1'b0;
    logic [ADDR_W:0]          BusyCnt;

    regfile_mp_sb #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .Flush(Flush), .BusyCnt(BusyCnt)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an array of register values and busy flags.
    logic [XLEN-1:0] m_reg  [NUM_REGS];
    bit              m_busy [NUM_REGS];

    function automatic void model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < NUM_REGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        bit wrote [NUM_REGS];
        for (int r = 0; r < NUM_REGS; r++) wrote[r] = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            int a;
            a = int'(WrAddr[k*ADDR_W +: ADDR_W]);
            if (WrEn[k] && a != 0 && a < NUM_REGS) begin
                m_reg[a] = WrData[k*XLEN +: XLEN];
                wrote[a] = 1'b1;
            end
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            if (IssueEn && int'(IssueAddr) == r) m_busy[r] = 1'b1;
            else if (Flush)                     m_busy[r] = 1'b0;
            else if (wrote[r])                  m_busy[r] = 1'b0;
        end
    endfunction

    function automatic void model_read(input int p, output logic [XLEN-1:0] d, output logic b);
        int a;
        a = int'(RdAddr[p*ADDR_W +: ADDR_W]);
        d = '0;
        b = 1'b0;
        if (!RdEn[p] || a == 0 || a >= NUM_REGS) return;
        d = m_reg[a];
        b = m_busy[a];
`ifdef REGFILE_WR_BYPASS_EN
        for (int k = 0; k < NUM_WR; k++) begin
            if (WrEn[k] && int'(WrAddr[k*ADDR_W +: ADDR_W]) == a) begin
                d = WrData[k*XLEN +: XLEN];
                b = IssueEn && (int'(IssueAddr) == a);
            end
        end
`endif
    endfunction

    task automatic check_model(input string tag);
        logic [XLEN-1:0] d;
        logic            b;
        for (int p = 0; p < NUM_RD; p++) begin
            model_read(p, d, b);
            chk($sformatf("%s_data%0d", tag, p), RdData[p*XLEN +: XLEN], d);
            chk($sformatf("%s_busy%0d", tag, p), 64'(RdBusy[p]), 64'(b));
        end
        chk($sformatf("%s_cnt", tag), 64'(BusyCnt), 64'(model_cnt()));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle_reads(input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3);
        WrEn    = '0;
        IssueEn = 1'b0;
        Flush   = 1'b0;
        RdEn    = '1;
        RdAddr  = {a3, a2, a1, a0};
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [3:0]  re;
        logic [4:0]  ra;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [63:0] exp_d;
        logic        exp_b;
        logic [63:0] byp_d;
        logic        byp_b;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [63:0] wd0,
        input logic [4:0] wa1, input logic [63:0] wd1, input logic [3:0] re,
        input logic [4:0] ra, input logic ie, input logic [4:0] ia, input logic fl,
        input logic [63:0] exp_d, input logic exp_b, input logic [63:0] byp_d,
        input logic byp_b, input logic [5:0] exp_cnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.re = re; v.ra = ra; v.ie = ie; v.ia = ia; v.fl = fl;
        v.exp_d = exp_d; v.exp_b = exp_b; v.byp_d = byp_d; v.byp_b = byp_b;
        v.exp_cnt = exp_cnt;
        return v;
    endfunction

    initial begin
        logic [63:0] ed;
        logic        eb;

        // Table columns: we wa0 wd0 wa1 wd1 re ra ie ia fl | exp_d exp_b byp_d byp_b cnt.
        // Expected values are the pre-edge outputs for that row's inputs.
        tbl[0]  = mk(2'b01,  5, 64'h1234,  0, 0,     4'hF,  5, 0,  0, 0, 0,        0, 64'h1234, 0, 0);
        tbl[1]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  5, 0,  0, 0, 64'h1234, 0, 64'h1234, 0, 0);
        tbl[2]  = mk(2'b11,  7, 64'hAA,    7, 64'hBB, 4'hF, 7, 0,  0, 0, 0,        0, 64'hBB,   0, 0);
        tbl[3]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  7, 0,  0, 0, 64'hBB,   0, 64'hBB,   0, 0);
        tbl[4]  = mk(2'b01,  0, 64'hFFFF,  0, 0,     4'hF,  0, 1,  0, 0, 0,        0, 0,        0, 0);
        tbl[5]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  0, 0,  0, 0, 0,        0, 0,        0, 0);
        tbl[6]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  3, 1,  3, 0, 0,        0, 0,        0, 0);
        tbl[7]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  3, 1,  9, 0, 0,        1, 0,        1, 1);
        tbl[8]  = mk(2'b00,  0, 0,         0, 0,     4'hF,  9, 0,  0, 0, 0,        1, 0,        1, 2);
        tbl[9]  = mk(2'b01,  3, 64'h33,    0, 0,     4'hF,  3, 1,  3, 0, 0,        1, 64'h33,   1, 2);
        tbl[10] = mk(2'b00,  0, 0,         0, 0,     4'hF,  3, 0,  0, 0, 64'h33,   1, 64'h33,   1, 2);
        tbl[11] = mk(2'b00,  0, 0,         0, 0,     4'hF,  9, 0,  0, 1, 0,        1, 0,        1, 2);
        tbl[12] = mk(2'b00,  0, 0,         0, 0,     4'hF,  9, 0,  0, 0, 0,        0, 0,        0, 0);
        tbl[13] = mk(2'b10,  0, 0,        12, 64'h55, 4'h5, 12, 0, 0, 0, 0,        0, 64'h55,   0, 0);
        tbl[14] = mk(2'b00,  0, 0,         0, 0,     4'hA, 12, 0,  0, 0, 64'h55,   0, 64'h55,   0, 0);
        tbl[15] = mk(2'b01, 12, 64'h66,    0, 0,     4'hF, 12, 1, 12, 1, 64'h55,   0, 64'h66,   1, 0);
        tbl[16] = mk(2'b00,  0, 0,         0, 0,     4'hF, 12, 0,  0, 0, 64'h66,   1, 64'h66,   1, 1);
        tbl[17] = mk(2'b10,  0, 0,        12, 64'h77, 4'hF, 12, 0, 0, 0, 64'h66,   1, 64'h77,   0, 1);
        tbl[18] = mk(2'b00,  0, 0,         0, 0,     4'hF, 12, 0,  0, 0, 64'h77,   0, 64'h77,   0, 0);

        // Reset state: the bench starts with Rst held low.
        model_reset();
        idle_reads(5'd1, 5'd2, 5'd3, 5'd31);
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("rst_data%0d", p), RdData[p*XLEN +: XLEN], 64'h0);
            chk($sformatf("rst_busy%0d", p), 64'(RdBusy[p]), 64'h0);
        end
        chk("rst_cnt", 64'(BusyCnt), 64'h0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            WrEn      = tbl[i].we;
            WrAddr    = {tbl[i].wa1, tbl[i].wa0};
            WrData    = {tbl[i].wd1, tbl[i].wd0};
            RdEn      = tbl[i].re;
            RdAddr    = {4{tbl[i].ra}};
            IssueEn   = tbl[i].ie;
            IssueAddr = tbl[i].ia;
            Flush     = tbl[i].fl;
            #1;
`ifdef REGFILE_WR_BYPASS_EN
            ed = tbl[i].byp_d;
            eb = tbl[i].byp_b;
`else
            ed = tbl[i].exp_d;
            eb = tbl[i].exp_b;
`endif
            for (int p = 0; p < NUM_RD; p++) begin
                chk($sformatf("v%0d_data%0d", i, p), RdData[p*XLEN +: XLEN],
                    tbl[i].re[p] ? ed : 64'h0);
                chk($sformatf("v%0d_busy%0d", i, p), 64'(RdBusy[p]),
                    64'(tbl[i].re[p] ? eb : 1'b0));
            end
            chk($sformatf("v%0d_cnt", i), 64'(BusyCnt), 64'(tbl[i].exp_cnt));
            tick();
        end

        // Load registers 1..4 and mark them busy, then reset mid-stream.
        for (int r = 1; r <= 4; r++) begin
            idle_reads(5'd1, 5'd2, 5'd3, 5'd4);
            WrEn      = 2'b01;
            WrAddr    = {5'd0, 5'(r)};
            WrData    = {64'h0, 64'h100 + 64'(r)};
            IssueEn   = 1'b1;
            IssueAddr = 5'(r);
            tick();
        end
        idle_reads(5'd1, 5'd2, 5'd3, 5'd4);
        #1;
        chk("pre_rst_cnt", 64'(BusyCnt), 64'd4);
        chk("pre_rst_data0", RdData[0 +: XLEN], 64'h101);
        chk("pre_rst_busy3", 64'(RdBusy[3]), 64'h1);
        WrEn      = 2'b01;
        WrAddr    = {5'd0, 5'd1};
        WrData    = {64'h0, 64'hDEAD};
        IssueEn   = 1'b1;
        IssueAddr = 5'd5;
        #1;
        Rst = 1'b0;
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("mid_rst_data%0d", p), RdData[p*XLEN +: XLEN], 64'h0);
            chk($sformatf("mid_rst_busy%0d", p), 64'(RdBusy[p]), 64'h0);
        end
        chk("mid_rst_cnt", 64'(BusyCnt), 64'h0);
        model_reset();
        @(posedge Clk);
        #1;
        chk("rst_hold_data0", RdData[0 +: XLEN], 64'h0);
        chk("rst_hold_cnt", 64'(BusyCnt), 64'h0);
        @(negedge Clk);
        Rst = 1'b1;
        idle_reads(5'd1, 5'd2, 5'd3, 5'd4);
        tick();
        chk("post_rst_data0", RdData[0 +: XLEN], 64'h0);
        chk("post_rst_busy0", 64'(RdBusy[0]), 64'h0);
        chk("post_rst_cnt", 64'(BusyCnt), 64'h0);

        // Random traffic against the model. Addresses are biased low to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            WrEn = 2'($urandom);
            for (int k = 0; k < NUM_WR; k++) begin
                WrAddr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 0) ?
                    5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                WrData[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            RdEn = 4'($urandom);
            for (int p = 0; p < NUM_RD; p++) begin
                RdAddr[p*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 0) ?
                    5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            IssueEn   = ($urandom_range(0, 2) == 0);
            IssueAddr = 5'($urandom_range(0, 9));
            Flush     = ($urandom_range(0, 40) == 0);
            #1;
            check_model("rnd");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next-generation general-purpose register file for the dual-issue core.
- N asynchronous read ports and M synchronous write ports.
- Per-register busy tracking, set at issue and cleared at writeback, so the decode stage can stall on RAW hazards without a separate scoreboard.
- Sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing).

Parameters:
XLEN, 64, data width of each register
NUM_REGS, 32, number of architectural registers; entry 0 is hard-wired zero
ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write ports

Ports:
Clk  input  1  clock, rising-edge
Rst  input  1  asynchronous, active-low reset
WrEn  input  NUM_WR  per-port write enable
WrAddr  input  NUM_WR*ADDR_W  write addresses; port k at bits [k*ADDR_W +: ADDR_W]
WrData  input  NUM_WR*XLEN  write data; port k at bits [k*XLEN +: XLEN]
RdEn  input  NUM_RD  per-port read enable
RdAddr  input  NUM_RD*ADDR_W  read addresses, packed as for WrAddr
RdData  output  NUM_RD*XLEN  read data, combinational
RdBusy  output  NUM_RD  busy bit of the addressed register, combinational
IssueEn  input  1  mark IssueAddr busy at next edge
IssueAddr  input  ADDR_W  destination register of the issuing instruction
Flush  input  1  clear all busy bits at next edge
BusyCnt  output  ADDR_W+1  registered population count of busy bits

Behaviour:
- Reset (Rst low, asynchronous):
  - All registers are cleared to 0.
  - All busy bits are cleared.
  - BusyCnt is 0.
  - RdData follows the cleared array, so it reads 0.
  - Reset asserted mid-operation discards pending writes, issues and flushes in that cycle.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it and issues to it are ignored.
- Out-of-range addresses (>= NUM_REGS):
  - Reads return 0 and not busy.
  - Writes and issues are ignored.
- Reads:
  - Combinational; zero latency from RdAddr/RdEn to RdData/RdBusy.
  - RdEn=0 forces that port's RdData=0 and RdBusy=0.
- Writes:
  - Committed on the rising Clk edge when WrEn[k]=1.
  - If two or more enabled ports target the same address in one cycle, the highest-index port wins.
- Busy bit update per register r != 0, evaluated at each edge in priority order:
  1. IssueEn && IssueAddr==r -> busy=1. This wins over a same-cycle write-clear and over Flush, because the new producer supersedes older state.
  2. Otherwise, Flush -> busy=0.
  3. Otherwise, any enabled write to r -> busy=0.
  4. Otherwise, busy holds.
- BusyCnt:
  - Equals the number of busy bits after each edge, with one cycle of latency from the causing event.
  - Range 0..NUM_REGS-1.
- Read during a same-cycle write to the same address: behaviour depends on the optional feature below.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled same-cycle write returns WrData of the highest-index matching write port.
  - RdBusy for that port reads 0, unless IssueEn targets the same address in that cycle, in which case it reads 1.
  - Register 0 and out-of-range addresses are never bypassed.
- Undefined:
  - Reads return the pre-edge array value and pre-edge busy bit.
  - The new data and cleared busy bit become visible the cycle after the edge.

Test Plan:
- Write port 0 {addr 5, data 0x1234} at edge, then read 5 on all four ports -> every RdData=0x1234, RdBusy=0.
- Same cycle: WrEn=2'b11 with both ports at addr 7, data 0xAA on port 0 and 0xBB on port 1 -> next read of 7 returns 0xBB.
- Write 0xFFFF to addr 0, IssueEn with IssueAddr=0 -> read 0 returns 0, RdBusy=0, BusyCnt stays 0.
- Issue addr 3, then addr 9 -> RdBusy(3)=RdBusy(9)=1, BusyCnt=2. Then write addr 3 with a same-cycle issue to addr 3 -> busy(3) stays 1. Then Flush -> BusyCnt=0.
- With REGFILE_WR_BYPASS_EN, write 0x55 to addr 12 and read 12 in the same cycle -> RdData=0x55 combinationally. Without the macro -> RdData=old value, and 0x55 appears the next cycle.
- Load registers 1..4 and mark them busy, then assert Rst low for 1 cycle mid-stream -> all RdData=0, all RdBusy=0, BusyCnt=0 immediately. A same-cycle write is discarded.
